// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   - S3->S4 bundle field widths and bit offsets
//   - S34_BUNDLE_W: total bundle width, used as the default payload width
//   - stage_state_e: handshake stage state, encoded as {skid_valid, main_valid}
package pipe_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int FLAGS_W   = 16;
  // Wide immediate field, so that the bundle fills its 143-bit allocation.
  localparam int IMM_W     = 48;

  // Fields packed from LSB: flags, imm, rs2 data, rs1 data, rd, rs2, rs1.
  localparam int FLAGS_LSB = 0;
  localparam int IMM_LSB   = FLAGS_LSB + FLAGS_W;
  localparam int RS2D_LSB  = IMM_LSB + IMM_W;
  localparam int RS1D_LSB  = RS2D_LSB + XLEN;
  localparam int RD_LSB    = RS1D_LSB + XLEN;
  localparam int RS2_LSB   = RD_LSB + REG_IDX_W;
  localparam int RS1_LSB   = RS2_LSB + REG_IDX_W;

  localparam int S34_BUNDLE_W = RS1_LSB + REG_IDX_W;  // 143

  // Bit 0 is main_valid and bit 1 is skid_valid. The value 2'b10 is illegal.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter for stage statistics.
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   clr        : synchronous clear
//   inc        : count-enable; the count holds at all-ones
//   cnt        : current count
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_latch_hs.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. in_ready comes straight from a register, so it never depends on
// out_ready combinationally. The stage also has a synchronous flush that
// turns all held entries into zero NOP bubbles, and it keeps occupancy and
// stall statistics.
//
//   state | meaning
//   EMPTY | no entry held; in_ready = 1
//   BUSY  | main holds the output entry; in_ready = 1
//   FULL  | main and skid both hold entries; in_ready = 0
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous kill of all held entries
//   in_valid/in_ready   : upstream handshake, with in_data as the payload
//   out_valid/out_ready : downstream handshake, with out_data from main
//   occupancy           : number of entries held (0..2)
//   stall_cnt           : saturating count of cycles with out_valid && !out_ready
module pipe_latch_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = S34_BUNDLE_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic drain;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any accept in this cycle is dropped, because upstream is flushed by
      // the same signal. A drain in this cycle still completes downstream.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: begin
          // The 2'b10 encoding cannot be reached. If it ever is, recover to
          // EMPTY rather than present a skid entry with no main entry.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush does not clear the stall statistics; only reset does.
  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_latch_hs.sv
module tb_pipe_latch_hs;
  localparam int DW  = 143;
  localparam int BDW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic            fl_a, iv_a, or_a, ir_a, ov_a;
  logic [DW-1:0]   id_a, od_a;
  logic [1:0]      occ_a;
  logic [15:0]     sc_a;

  logic            fl_b, iv_b, or_b, ir_b, ov_b;
  logic [BDW-1:0]  id_b, od_b;
  logic [1:0]      occ_b;
  logic [2:0]      sc_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_latch_hs #(.DATA_W(DW), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(fl_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .occupancy(occ_a), .stall_cnt(sc_a)
  );

  pipe_latch_hs #(.DATA_W(BDW), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(fl_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .occupancy(occ_b), .stall_cnt(sc_b)
  );

  // The payload marks both the top and the bottom byte.
  function automatic logic [DW-1:0] pl(input logic [7:0] v);
    return {v, {(DW-16){1'b0}}, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fl_a = 0; iv_a = 0; or_a = 0; id_a = '0;
    fl_b = 0; iv_b = 0; or_b = 0; id_b = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", ov_a); end
    checks++; if (ir_a !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", ir_a); end
    checks++; if (od_a !== '0) begin errs++; $display("FAIL reset_out_data got=%h exp=0", od_a); end
    checks++; if (occ_a !== 2'd0) begin errs++; $display("FAIL reset_occupancy got=%0d exp=0", occ_a); end
    checks++; if (sc_a !== 16'd0) begin errs++; $display("FAIL reset_stall_cnt got=%0d exp=0", sc_a); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] v;
    v = '0;
    v[15:0] = 16'hABCD;
    v[DW-1:DW-8] = 8'h5A;
    iv_a = 1; id_a = v; or_a = 1;
    tick();
    iv_a = 0;
    checks++; if (ov_a !== 1'b1) begin errs++; $display("FAIL single_valid got=%b exp=1", ov_a); end
    checks++; if (od_a !== v) begin errs++; $display("FAIL single_data got=%h exp=%h", od_a, v); end
    checks++; if (occ_a !== 2'd1) begin errs++; $display("FAIL single_occ got=%0d exp=1", occ_a); end
    tick();
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL single_valid_after got=%b exp=0", ov_a); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    int sent = 0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      or_a = (c == 0) || (c >= 4);
      iv_a = (sent < 4);
      id_a = pl(8'(sent + 1));
      if (c == 2) begin
        checks++; if (occ_a !== 2'd2) begin errs++; $display("FAIL bp_occ got=%0d exp=2", occ_a); end
        checks++; if (ir_a !== 1'b0) begin errs++; $display("FAIL bp_in_ready got=%b exp=0", ir_a); end
        checks++; if (od_a !== pl(8'd1)) begin errs++; $display("FAIL bp_main_data got=%h exp=%h", od_a, pl(8'd1)); end
      end
      if (ov_a && or_a) got.push_back(od_a);
      if (iv_a && ir_a) sent++;
      tick();
    end
    iv_a = 0;
    checks++; if (got.size() != 4) begin errs++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== pl(8'(i + 1))) begin errs++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], pl(8'(i + 1))); end
    end
    // Stall cycles: c=1, 2, 3.
    checks++; if (sc_a !== 16'd3) begin errs++; $display("FAIL bp_stall_cnt got=%0d exp=3", sc_a); end
  endtask

  task automatic test_flush_full();
    or_a = 0;
    iv_a = 1; id_a = pl(8'h11); tick();
    id_a = pl(8'h22); tick();
    checks++; if (occ_a !== 2'd2) begin errs++; $display("FAIL ff_pre_occ got=%0d exp=2", occ_a); end
    fl_a = 1; id_a = pl(8'h33); tick();
    fl_a = 0; iv_a = 0;
    checks++; if (occ_a !== 2'd0) begin errs++; $display("FAIL ff_occ got=%0d exp=0", occ_a); end
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL ff_valid got=%b exp=0", ov_a); end
    checks++; if (od_a !== '0) begin errs++; $display("FAIL ff_data got=%h exp=0", od_a); end
    checks++; if (ir_a !== 1'b1) begin errs++; $display("FAIL ff_in_ready got=%b exp=1", ir_a); end
    // An accept presented in a flush cycle from EMPTY is discarded.
    fl_a = 1; iv_a = 1; id_a = pl(8'h44); tick();
    fl_a = 0; iv_a = 0;
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL ff_accept_dropped got=%b exp=0", ov_a); end
    tick();
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL ff_accept_dropped2 got=%b exp=0", ov_a); end
  endtask

  task automatic test_flush_drain();
    int xfers = 0;
    or_a = 0; iv_a = 1; id_a = pl(8'h55); tick();
    iv_a = 0; or_a = 1; fl_a = 1;
    if (ov_a && or_a) xfers++;
    checks++; if (od_a !== pl(8'h55)) begin errs++; $display("FAIL fd_data got=%h exp=%h", od_a, pl(8'h55)); end
    tick();
    fl_a = 0;
    if (ov_a && or_a) xfers++;
    tick();
    if (ov_a && or_a) xfers++;
    checks++; if (xfers != 1) begin errs++; $display("FAIL fd_xfers got=%0d exp=1", xfers); end
    checks++; if (occ_a !== 2'd0) begin errs++; $display("FAIL fd_occ got=%0d exp=0", occ_a); end
  endtask

  task automatic test_back_to_back();
    or_a = 1; iv_a = 1; id_a = pl(8'h80);
    tick();
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (ov_a !== 1'b1 || od_a !== pl(8'(8'h80 + c - 1)) || ir_a !== 1'b1) begin
        errs++;
        $display("FAIL b2b c=%0d got_v=%b got_d=%h got_ir=%b exp_d=%h", c, ov_a, od_a, ir_a, pl(8'(8'h80 + c - 1)));
      end
      iv_a = (c < 8);
      id_a = pl(8'(8'h80 + c));
      tick();
    end
    iv_a = 0;
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL b2b_end_valid got=%b exp=0", ov_a); end
  endtask

  task automatic test_stall_sat();
    iv_b = 1; id_b = 8'h5A; or_b = 0; tick();
    iv_b = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (sc_b !== 3'd5) begin errs++; $display("FAIL sat_mid got=%0d exp=5", sc_b); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (sc_b !== 3'd7) begin errs++; $display("FAIL sat_full got=%0d exp=7", sc_b); end
    checks++; if (od_b !== 8'h5A) begin errs++; $display("FAIL sat_hold_data got=%h exp=5a", od_b); end
    fl_b = 1; tick();
    fl_b = 0;
    checks++; if (sc_b !== 3'd7) begin errs++; $display("FAIL sat_after_flush got=%0d exp=7", sc_b); end
    checks++; if (ov_b !== 1'b0) begin errs++; $display("FAIL sat_flush_valid got=%b exp=0", ov_b); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sc_b !== 3'd0) begin errs++; $display("FAIL sat_reset got=%0d exp=0", sc_b); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    or_a = 0; iv_a = 1; id_a = pl(8'h66); tick();
    id_a = pl(8'h77); tick();
    iv_a = 0;
    checks++; if (occ_a !== 2'd2) begin errs++; $display("FAIL rm_pre_occ got=%0d exp=2", occ_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov_a !== 1'b0) begin errs++; $display("FAIL rm_valid got=%b exp=0", ov_a); end
    checks++; if (ir_a !== 1'b1) begin errs++; $display("FAIL rm_in_ready got=%b exp=1", ir_a); end
    checks++; if (od_a !== '0) begin errs++; $display("FAIL rm_data got=%h exp=0", od_a); end
    checks++; if (occ_a !== 2'd0) begin errs++; $display("FAIL rm_occ got=%0d exp=0", occ_a); end
    checks++; if (sc_a !== 16'd0) begin errs++; $display("FAIL rm_stall got=%0d exp=0", sc_a); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush_full();
    test_flush_drain();
    test_back_to_back();
    test_stall_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
